// File: rtl/grey_pkg.sv
// grey_pkg: shared definitions for the Gray-code step checker.
// Holds the default code width, the checker FSM state type and the
// Gray/binary helper functions (successor, Gray->binary, binary->Gray).
// The helpers work on 32-bit vectors; callers zero-extend narrower codes
// and pass the real code width so the successor wraps correctly.
package grey_pkg;

    localparam int GREY_WIDTH = 6;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2,
        ST_RSVD  = 2'd3
    } grey_state_e;

    // Gray -> binary: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [31:0] f_grey2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Binary -> Gray: reflected binary code.
    function automatic logic [31:0] f_bin2grey(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray successor of g for a code of width w (wraps from all-ones binary to 0).
    function automatic logic [31:0] f_grey6(input logic [31:0] g, input logic [31:0] w);
        logic [31:0] mask;
        logic [31:0] b;
        if (w >= 32'd32) begin
            mask = 32'hFFFF_FFFF;
        end else begin
            mask = (32'd1 << w) - 32'd1;
        end
        b = (f_grey2bin(g & mask) + 32'd1) & mask;
        return f_bin2grey(b);
    endfunction

endpackage

// File: rtl/grey2bin.sv
// grey2bin: purely combinational Gray-to-binary converter used to drive
// the binary view of the last accepted code.
module grey2bin
    import grey_pkg::*;
#(
    parameter int WIDTH = GREY_WIDTH
) (
    input  logic [WIDTH-1:0] grey_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit folds every Gray bit from itself up to the MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^grey_i[WIDTH-1:i];
    end

endmodule

// File: rtl/grey_check.sv
// grey_check: monitors a Gray counter and classifies every change as a
// legal single step (exact Gray successor, including wrap-around) or an
// illegal step. Legal steps are counted (wrapping 16-bit counter), illegal
// steps are counted in a saturating counter and raise a sticky flag.
//
// Pipeline: grey_in is captured into stage 1; stage 1 is compared with the
// stored reference and the registered outputs update on the following edge,
// i.e. two edges after grey_in changes.
//
// Build option: define GREY_CHECK_BIN_EN to drive bin_out with the binary
// value of the last accepted code. Without it bin_out stays 0 and no
// conversion logic exists; successor checking is identical in both builds.
//
// The stage-1 valid bit makes sure that after reset the first value that
// is actually sampled from grey_in (not the reset value of stage 1) is the
// one taken as the unchecked starting reference.
module grey_check
    import grey_pkg::*;
#(
    parameter int WIDTH = GREY_WIDTH,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] grey_in,
    output logic [WIDTH-1:0] bin_out,
    output logic [15:0]      step_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             err_flag,
    output logic [1:0]       state_o
);

    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

    logic [WIDTH-1:0] stage1_q;
    logic             s1_vld_q;

    grey_state_e      state_q, state_d;
    logic [WIDTH-1:0] ref_q,   ref_d;
    logic [WIDTH-1:0] bin_q,   bin_d;
    logic [15:0]      step_q,  step_d;
    logic [ERR_W-1:0] err_q,   err_d;
    logic             flag_q,  flag_d;

    logic [WIDTH-1:0] succ_s;
    logic [WIDTH-1:0] conv_s;
    logic             event_s;
    logic             legal_s;

    // Stage 1: capture the incoming Gray code every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage1_q <= '0;
            s1_vld_q <= 1'b0;
        end else begin
            stage1_q <= grey_in;
            s1_vld_q <= 1'b1;
        end
    end

    assign succ_s  = WIDTH'(f_grey6(32'(ref_q), 32'(WIDTH)));
    assign event_s = (stage1_q != ref_q);
    assign legal_s = (stage1_q == succ_s);

`ifdef GREY_CHECK_BIN_EN
    grey2bin #(
        .WIDTH (WIDTH)
    ) u_grey2bin (
        .grey_i (stage1_q),
        .bin_o  (conv_s)
    );
`else
    assign conv_s = '0;
`endif

    // Stage 2: next-state, reference and counter decisions.
    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        bin_d   = bin_q;
        step_d  = step_q;
        err_d   = err_q;
        flag_d  = flag_q;

        if (clr) begin
            // Clear wins over any event seen on the same edge.
            state_d = ST_SYNC;
            ref_d   = '0;
            bin_d   = '0;
            step_d  = 16'd0;
            err_d   = '0;
            flag_d  = 1'b0;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (s1_vld_q) begin
                        // First sampled value becomes the reference unchecked.
                        ref_d   = stage1_q;
                        bin_d   = conv_s;
                        state_d = ST_TRACK;
                    end else begin
                        state_d = ST_SYNC;
                    end
                end
                ST_TRACK, ST_FAULT: begin
                    if (event_s) begin
                        if (legal_s) begin
                            ref_d  = stage1_q;
                            bin_d  = conv_s;
                            step_d = step_q + 16'd1;
                        end else begin
                            ref_d   = stage1_q;
                            err_d   = (err_q == ERR_MAX) ? err_q : (err_q + ERR_W'(1));
                            flag_d  = 1'b1;
                            state_d = ST_FAULT;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    // Unused encoding: drop back and resynchronise.
                    state_d = ST_SYNC;
                end
            endcase
        end
    end

    // Stage 2 registers: all outputs come straight from flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SYNC;
            ref_q   <= '0;
            bin_q   <= '0;
            step_q  <= 16'd0;
            err_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            bin_q   <= bin_d;
            step_q  <= step_d;
            err_q   <= err_d;
            flag_q  <= flag_d;
        end
    end

    assign bin_out  = bin_q;
    assign step_cnt = step_q;
    assign err_cnt  = err_q;
    assign err_flag = flag_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_grey_check.sv
// tb_grey_check: randomized + directed bench for grey_check (WIDTH=6, ERR_W=8).
// A table-driven behavioural model tracks the expected outputs; one
// process compares DUT against the model on every falling edge, and the
// directed scenarios add literal expectations.
module tb_grey_check;

`ifdef GREY_CHECK_BIN_EN
    localparam bit BIN_EN = 1'b1;
`else
    localparam bit BIN_EN = 1'b0;
`endif

    localparam int N = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr = 1'b0;
    logic [5:0] grey_in = 6'd0;
    logic [5:0] bin_out;
    logic [15:0] step_cnt;
    logic [7:0] err_cnt;
    logic       err_flag;
    logic [1:0] state_o;

    grey_check #(.WIDTH(6), .ERR_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .grey_in  (grey_in),
        .bin_out  (bin_out),
        .step_cnt (step_cnt),
        .err_cnt  (err_cnt),
        .err_flag (err_flag),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Lookup tables: gray_of[b] is the Gray code of b, bin_of inverts it.
    int gray_of [N];
    int bin_of  [N];

    // Model state: mode 0=SYNC 1=TRACK 2=FAULT; reference kept as binary.
    int m_s1 = 0;
    bit m_vld = 1'b0;
    int m_mode = 0;
    int m_ref = 0;
    int m_bin = 0;
    int m_step = 0;
    int m_err = 0;
    bit m_flag = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
        end
    endtask

    initial begin
        for (int b = 0; b < N; b++) begin
            gray_of[b] = b ^ (b / 2);
            bin_of[gray_of[b]] = b;
        end
    end

    // Behavioural model advancing on every clock edge or reset assertion.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_s1 = 0; m_vld = 1'b0; m_mode = 0; m_ref = 0;
                m_bin = 0; m_step = 0; m_err = 0; m_flag = 1'b0;
            end else begin
                if (clr) begin
                    m_mode = 0; m_ref = 0; m_bin = 0; m_step = 0; m_err = 0; m_flag = 1'b0;
                end else if (m_mode == 0) begin
                    if (m_vld) begin
                        m_ref = bin_of[m_s1];
                        m_bin = m_ref;
                        m_mode = 1;
                    end
                end else if (gray_of[m_ref] != m_s1) begin
                    if (bin_of[m_s1] == (m_ref + 1) % N) begin
                        m_ref = bin_of[m_s1];
                        m_bin = m_ref;
                        m_step = (m_step + 1) % 65536;
                    end else begin
                        m_ref = bin_of[m_s1];
                        if (m_err < 255) m_err = m_err + 1;
                        m_flag = 1'b1;
                        m_mode = 2;
                    end
                end
                m_s1 = int'(grey_in);
                m_vld = 1'b1;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("bin_out",  32'(bin_out),  BIN_EN ? 32'(m_bin) : 32'd0);
            chk("step_cnt", 32'(step_cnt), 32'(m_step));
            chk("err_cnt",  32'(err_cnt),  32'(m_err));
            chk("err_flag", 32'(err_flag), 32'(m_flag));
            chk("state_o",  32'(state_o),  32'(m_mode));
        end
    end

    task automatic drive(input logic [5:0] v, input int cycles);
        grey_in = v;
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        int cur;
        int r;
        @(negedge clk);
        chk("rst_bin",   32'(bin_out),  32'd0);
        chk("rst_step",  32'(step_cnt), 32'd0);
        chk("rst_err",   32'(err_cnt),  32'd0);
        chk("rst_state", 32'(state_o),  32'd0);
        rst = 1'b0;

        // Basic count 0,1,3,2.
        drive(6'd0, 4); drive(6'd1, 4); drive(6'd3, 4); drive(6'd2, 4);
        chk("seq_bin",   32'(bin_out),  BIN_EN ? 32'd3 : 32'd0);
        chk("seq_step",  32'(step_cnt), 32'd3);
        chk("seq_err",   32'(err_cnt),  32'd0);
        chk("seq_state", 32'(state_o),  32'd1);

        // Two-bit jump, then a legal step while in FAULT.
        drive(6'd7, 4);
        chk("jump_err",   32'(err_cnt),  32'd1);
        chk("jump_flag",  32'(err_flag), 32'd1);
        chk("jump_state", 32'(state_o),  32'd2);
        drive(6'd5, 4);
        chk("fault_step",  32'(step_cnt), 32'd4);
        chk("fault_err",   32'(err_cnt),  32'd1);
        chk("fault_state", 32'(state_o),  32'd2);
        chk("fault_bin",   32'(bin_out),  BIN_EN ? 32'd6 : 32'd0);

        // Wrap-around through 6'h20 -> 6'h00.
        clr = 1'b1; grey_in = 6'h21;
        @(negedge clk);
        clr = 1'b0;
        drive(6'h21, 4);
        chk("wrap_load", 32'(bin_out), BIN_EN ? 32'd62 : 32'd0);
        drive(6'h20, 4);
        chk("wrap_bin63", 32'(bin_out), BIN_EN ? 32'd63 : 32'd0);
        drive(6'h00, 4);
        chk("wrap_bin0",  32'(bin_out),  32'd0);
        chk("wrap_err",   32'(err_cnt),  32'd0);
        chk("wrap_step",  32'(step_cnt), 32'd2);

        // Backward single-bit step 3 -> 1 is illegal.
        drive(6'd1, 4); drive(6'd3, 4); drive(6'd1, 4);
        chk("back_err", 32'(err_cnt), 32'd1);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 6'd7 : 6'd0, 1);
        drive(6'd0, 4);
        chk("sat_err",  32'(err_cnt),  32'd255);
        chk("sat_flag", 32'(err_flag), 32'd1);
        drive(6'd7, 1); drive(6'd0, 4);
        chk("sat_hold", 32'(err_cnt), 32'd255);

        // Clear coinciding with a further jump.
        grey_in = 6'h3F;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk("clr_err",   32'(err_cnt),  32'd0);
        chk("clr_flag",  32'(err_flag), 32'd0);
        chk("clr_state", 32'(state_o),  32'd0);
        chk("clr_step",  32'(step_cnt), 32'd0);
        @(negedge clk);
        chk("clr_resync", 32'(state_o), 32'd1);

        // Asynchronous reset between edges.
        drive(6'h3E, 4);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_bin",   32'(bin_out),  32'd0);
        chk("arst_step",  32'(step_cnt), 32'd0);
        chk("arst_err",   32'(err_cnt),  32'd0);
        chk("arst_flag",  32'(err_flag), 32'd0);
        chk("arst_state", 32'(state_o),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(6'h15, 4);
        chk("arst_first_state", 32'(state_o), 32'd1);
        chk("arst_first_err",   32'(err_cnt), 32'd0);
        chk("arst_first_bin",   32'(bin_out), BIN_EN ? 32'd25 : 32'd0);

        // Randomized traffic: mostly legal steps with backward, random and clear mixed in.
        cur = 6'h15;
        for (int k = 0; k < 2000; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      cur = gray_of[(bin_of[cur] + 1) % N];
            else if (r == 6) cur = gray_of[(bin_of[cur] + N - 1) % N];
            else if (r == 7) cur = $urandom_range(0, N - 1);
            if ($urandom_range(0, 40) == 0) clr = 1'b1;
            drive(6'(cur), 1);
            clr = 1'b0;
            drive(6'(cur), $urandom_range(0, 2));
        end
        drive(6'(cur), 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
